// File: rtl/countdown_timer.sv
// Countdown timer core: BCD mm:ss count, button-driven set/run/pause FSM and
// 1 Hz prescaler feeding the seven-segment driver. All outputs are registered.
module countdown_timer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_start_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [1:0] flick_o,
    output logic       time_out_o,
    output logic [2:0] state_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_MIN = 3'd1,
        S_SET_SEC = 3'd2,
        S_RUN     = 3'd3,
        S_PAUSE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    min_q, min_d, sec_q, sec_d;
    logic [7:0]    pmin_q, pmin_d, psec_q, psec_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          prev_mode, prev_inc, prev_start;
    logic          press_mode, press_inc, press_start;
    logic [1:0]    flick_d;
    logic          time_out_d;
    logic [7:0]    dec_min, dec_sec;
    logic          count_zero;

    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 00 wraps to 59; only reached for seconds, minutes are nonzero whenever sec borrows
    function automatic logic [7:0] bcd_dec59(input logic [7:0] v);
        if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
        if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return 8'h59;
    endfunction

    assign press_mode  = btn_mode_i  & ~prev_mode;
    assign press_inc   = btn_inc_i   & ~prev_inc;
    assign press_start = btn_start_i & ~prev_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            pmin_q     <= 8'h00;
            psec_q     <= 8'h00;
            pre_q      <= '0;
            flick_o    <= 2'b00;
            time_out_o <= 1'b0;
            prev_mode  <= 1'b1;
            prev_inc   <= 1'b1;
            prev_start <= 1'b1;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            pmin_q     <= pmin_d;
            psec_q     <= psec_d;
            pre_q      <= pre_d;
            flick_o    <= flick_d;
            time_out_o <= time_out_d;
            prev_mode  <= btn_mode_i;
            prev_inc   <= btn_inc_i;
            prev_start <= btn_start_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        pmin_d     = pmin_q;
        psec_d     = psec_q;
        pre_d      = pre_q;
        dec_sec    = bcd_dec59(sec_q);
        dec_min    = (sec_q == 8'h00) ? bcd_dec59(min_q) : min_q;
        count_zero = ({min_q, sec_q} == 16'h0000);
        unique case (state_q)
            S_IDLE, S_SET_MIN, S_SET_SEC: begin
                if (press_start) begin
                    if (!count_zero) begin
                        state_d = S_RUN;
                        pmin_d  = min_q;
                        psec_d  = sec_q;
                        pre_d   = '0;
                    end
                end else if (press_mode) begin
                    state_d = (state_q == S_IDLE)    ? S_SET_MIN :
                              (state_q == S_SET_MIN) ? S_SET_SEC : S_IDLE;
                end else if (press_inc) begin
                    if (state_q == S_SET_MIN) min_d = bcd_inc59(min_q);
                    if (state_q == S_SET_SEC) sec_d = bcd_inc59(sec_q);
                end
            end
            S_RUN: begin
                // a start landing on a tick edge pauses first; the tick is taken after resume
                if (press_start) begin
                    state_d = S_PAUSE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    min_d = dec_min;
                    sec_d = dec_sec;
                    if ({dec_min, dec_sec} == 16'h0000) state_d = S_DONE;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (press_start) begin
                    state_d = S_RUN;
                end else if (press_mode) begin
                    state_d = S_IDLE;
                    min_d   = pmin_q;
                    sec_d   = psec_q;
                    pre_d   = '0;
                end
            end
            S_DONE: begin
                if (press_start || press_mode) begin
                    state_d = S_IDLE;
                    min_d   = pmin_q;
                    sec_d   = psec_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flick_d    = 2'b00;
        time_out_d = 1'b0;
        unique case (state_d)
            S_SET_MIN: flick_d = 2'b10;
            S_SET_SEC: flick_d = 2'b01;
            S_PAUSE:   flick_d = 2'b11;
            S_DONE:    time_out_d = 1'b1;
            default:   flick_d = 2'b00;
        endcase
    end

    assign min_o   = min_q;
    assign sec_o   = sec_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV = 4: vector tables for the
// run/pause sequences plus hand-written loops for field wrap and the long countdown.
module tb_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_SMIN = 3'd1, ST_SSEC = 3'd2,
                           ST_RUN = 3'd3, ST_PAUSE = 3'd4, ST_DONE = 3'd5;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_inc, btn_start;
    logic [7:0] min_o, sec_o;
    logic [1:0] flick_o;
    logic       time_out_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       m;
        logic       i;
        logic       s;
        logic [7:0] emin;
        logic [7:0] esec;
        logic [1:0] efl;
        logic       eto;
        logic [2:0] est;
    } vec_t;
    vec_t vecs[$];

    countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode_i  (btn_mode),
        .btn_inc_i   (btn_inc),
        .btn_start_i (btn_start),
        .min_o       (min_o),
        .sec_o       (sec_o),
        .flick_o     (flick_o),
        .time_out_o  (time_out_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] emin, input logic [7:0] esec,
                             input logic [1:0] efl, input logic eto, input logic [2:0] est);
        check({tag, ".min"},   min_o, emin);
        check({tag, ".sec"},   sec_o, esec);
        check({tag, ".flick"}, 8'(flick_o), 8'(efl));
        check({tag, ".tout"},  8'(time_out_o), 8'(eto));
        check({tag, ".state"}, 8'(state_o), 8'(est));
    endtask

    // inputs change on the falling edge, outputs are sampled 1 ns after the rising edge
    task automatic cycle(input logic m, input logic i, input logic s);
        @(negedge clk);
        btn_mode  = m;
        btn_inc   = i;
        btn_start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic m, input logic i, input logic s, input logic [7:0] emin,
                       input logic [7:0] esec, input logic [1:0] efl, input logic eto,
                       input logic [2:0] est);
        vec_t v;
        v.m = m; v.i = i; v.s = s;
        v.emin = emin; v.esec = esec; v.efl = efl; v.eto = eto; v.est = est;
        vecs.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            cycle(vecs[k].m, vecs[k].i, vecs[k].s);
            check_all($sformatf("%s[%0d]", tag, k), vecs[k].emin, vecs[k].esec,
                      vecs[k].efl, vecs[k].eto, vecs[k].est);
        end
        vecs.delete();
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    initial begin
        int esec_n;
        rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1; btn_start = 1'b1;

        // reset with every button held, then keep holding: no press may register
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        check_all("reset", 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 1);
            check_all($sformatf("held%0d", k), 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);
        end
        cycle(0, 0, 0);
        check_all("release", 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);

        // set minutes with wrap, then seconds
        cycle(1, 0, 0);
        check_all("to_smin", 8'h00, 8'h00, 2'b10, 1'b0, ST_SMIN);
        cycle(0, 0, 0);
        for (int k = 1; k <= 61; k++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
            if (k == 60) check("min_wrap", min_o, 8'h00);
        end
        check_all("min61", 8'h01, 8'h00, 2'b10, 1'b0, ST_SMIN);
        cycle(1, 0, 0);
        check_all("to_ssec", 8'h01, 8'h00, 2'b01, 1'b0, ST_SSEC);
        cycle(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        check_all("sec5", 8'h01, 8'h05, 2'b01, 1'b0, ST_SSEC);
        for (int k = 0; k < 56; k++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        check("sec_wrap", sec_o, 8'h01);
        cycle(1, 0, 0);
        check_all("to_idle", 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        check_all("idle_inc", 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        cycle(0, 0, 0);

        // countdown from 01:01: first tick 4 edges after entry
        add(0, 0, 1, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h00, 8'h59, 2'b00, 1'b0, ST_RUN);
        run_table("count");

        esec_n = 59;
        for (int c = 1; c <= 236; c++) begin
            cycle(0, 0, 0);
            if (c % 4 == 0) esec_n--;
            if (c == 236)
                check_all("reach_done", 8'h00, 8'h00, 2'b00, 1'b1, ST_DONE);
            else
                check_all($sformatf("down%0d", c), 8'h00, to_bcd(esec_n), 2'b00, 1'b0, ST_RUN);
        end

        add(0, 0, 0, 8'h00, 8'h00, 2'b00, 1'b1, ST_DONE);
        add(0, 1, 0, 8'h00, 8'h00, 2'b00, 1'b1, ST_DONE);
        add(0, 0, 0, 8'h00, 8'h00, 2'b00, 1'b1, ST_DONE);
        add(1, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        run_table("done");

        // pause at pre=2, resume, then a start that lands on a tick edge
        add(0, 0, 1, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 1, 8'h01, 8'h01, 2'b11, 1'b0, ST_PAUSE);
        for (int k = 0; k < 20; k++) add(0, 0, 0, 8'h01, 8'h01, 2'b11, 1'b0, ST_PAUSE);
        add(0, 0, 1, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 1, 8'h01, 8'h00, 2'b11, 1'b0, ST_PAUSE);
        add(0, 0, 0, 8'h01, 8'h00, 2'b11, 1'b0, ST_PAUSE);
        add(0, 0, 1, 8'h01, 8'h00, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 0, 8'h00, 8'h59, 2'b00, 1'b0, ST_RUN);
        add(0, 0, 1, 8'h00, 8'h59, 2'b11, 1'b0, ST_PAUSE);
        add(0, 0, 0, 8'h00, 8'h59, 2'b11, 1'b0, ST_PAUSE);
        add(1, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        add(0, 0, 0, 8'h01, 8'h01, 2'b00, 1'b0, ST_IDLE);
        run_table("pause");

        // simultaneous presses: start wins, minutes untouched
        cycle(1, 0, 0);
        check_all("smin2", 8'h01, 8'h01, 2'b10, 1'b0, ST_SMIN);
        cycle(0, 0, 0);
        cycle(1, 1, 1);
        check_all("simul", 8'h01, 8'h01, 2'b00, 1'b0, ST_RUN);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // reset mid-run, then a start at 00:00 is refused
        rst = 1'b1;
        cycle(0, 0, 0);
        check_all("rst_run", 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);
        rst = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        check_all("start_zero", 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);
        cycle(0, 0, 0);
        check_all("stay_idle", 8'h00, 8'h00, 2'b00, 1'b0, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown timer core that sits directly upstream of the seven-segment display driver. It owns the BCD minute/second count, the button-driven set/run/pause state machine, and the 1 Hz prescaler. It drives the driver's minute/second digit inputs, 2-bit field-flash select and time-out flag. All outputs are registered and change only on `clk`.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per one-second tick. Legal range is ≥2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode_i`  in  1  debounced level; a rising edge advances the set field.
- `btn_inc_i`  in  1  debounced level; a rising edge increments the selected field.
- `btn_start_i`  in  1  debounced level; a rising edge starts, pauses or resumes the countdown.
- `min_o`  out  8  minutes as BCD: `[7:4]` tens, `[3:0]` units, range 00–59.
- `sec_o`  out  8  seconds as BCD, range 00–59.
- `flick_o`  out  2  `[1]` flashes the minute digits, `[0]` flashes the second digits.
- `time_out_o`  out  1  high while in DONE.

## Operation
- **Edge detect.** One `prev` register per button. `press = level & ~prev`. Every `prev` resets to 1, so a button held through reset does not produce a press.
- **Press priority.** Start > mode > inc. At most one press is acted on per cycle; the other presses in that cycle are discarded.
- **Registers.**
  - count `{min,sec}`: drives the outputs.
  - preset `{pmin,psec}`: value to reload.
  - prescaler `pre`: 0..TICK_DIV-1.
  - state.
- **States.** IDLE, SET_MIN, SET_SEC, RUN, PAUSE, DONE. Reset state is IDLE.
- **IDLE**
  - mode → SET_MIN.
  - start with count ≠ 00:00 → RUN: preset ← count, `pre` ← 0.
  - start with count = 00:00: ignored.
  - inc: ignored.
- **SET_MIN**
  - inc: `min` BCD +1; units 9 → 0 with tens +1; 59 → 00. `sec` is untouched.
  - mode → SET_SEC.
  - start: same as start in IDLE.
- **SET_SEC**
  - inc: same as SET_MIN, applied to `sec`.
  - mode → IDLE.
  - start: same as start in IDLE.
- **RUN**
  - `pre` increments every cycle. When `pre == TICK_DIV-1`: `pre` ← 0 and the count decrements by one second.
  - Decrement rules: `sec` units 0 → 9 with tens −1; `sec` 00 → 59 with `min` −1.
  - If the decremented value is 00:00, go to DONE in the same cycle.
  - start → PAUSE; `pre` holds its value.
  - mode and inc: ignored.
- **PAUSE**
  - start → RUN; `pre` resumes from the held value.
  - mode → IDLE: count ← preset, `pre` ← 0.
  - inc: ignored.
- **DONE**
  - Count holds at 00:00.
  - start or mode → IDLE: count ← preset.
  - inc: ignored.
- **`flick_o`**: SET_MIN = 10, SET_SEC = 01, PAUSE = 11, all other states = 00.
- **`time_out_o`**: 1 exactly while in DONE.
- **Count range.** The count never leaves 00:00–59:59, and each BCD nibble stays ≤ 9.
- **Reset.** `rst` asserted in any state, including mid-tick:
  - state ← IDLE.
  - count, preset and `pre` ← 0.
  - `flick_o` = 00, `time_out_o` = 0, `min_o` = `sec_o` = 8'h00.

## Timing
- **Press latency.** Button low at edge k−1 and high at edge k: the state and output update is visible after edge k, i.e. one cycle of latency.
- **Tick cadence.** The first decrement after entering RUN (with `pre` = 0) occurs at the TICK_DIV-th rising edge after the entry edge. After that, one decrement every TICK_DIV cycles.
- **Reaching DONE.** The edge that decrements to 00:00 also sets state = DONE and `time_out_o` = 1.
- **Pause/resume.** A pause/resume pair loses no prescaler cycles.
- **Start on a tick edge.** If start arrives in RUN on the same edge as a tick, the pause wins: no decrement occurs, and `pre` holds at TICK_DIV-1. The deferred decrement then occurs on the first edge after resume.
- **Output registers.** Outputs come straight from registers, with no combinational path from inputs to outputs.

## Test plan
Benches run with TICK_DIV = 4.

1. **Reset with button held.** Assert `rst` with all buttons held high, release `rst`, hold the buttons 3 cycles → state IDLE, `min_o` = `sec_o` = 00, `flick_o` = 00, `time_out_o` = 0, and no press is acted on.
2. **Set fields and wrap.**
   - mode, then 61 inc presses → `min_o` = 8'h01 (59 → 00 wrap seen), `flick_o` = 10.
   - mode, then 5 inc presses → `sec_o` = 8'h05, `flick_o` = 01.
   - mode → `flick_o` = 00.
3. **Countdown to DONE.**
   - From 01:01, start → after 4 cycles the count is 01:00; after 8 cycles it is 00:59; `sec_o` shows 8'h59.
   - Continue → 00:00 is reached on the tick edge, with `time_out_o` = 1 on that same edge.
4. **Pause/resume and tick collision.**
   - Pause at `pre` = 2 → `flick_o` = 11, count frozen for 20 cycles.
   - Resume → the next decrement comes exactly 2 cycles later.
   - Start coincident with a tick → no decrement.
5. **Reload and rejected start.**
   - From DONE, press mode → IDLE with count = preset 01:01.
   - From IDLE at 00:00, start → stays IDLE.
6. **Simultaneous presses and reset mid-run.**
   - Start + mode + inc on the same cycle in SET_MIN → RUN, `min` unchanged.
   - `rst` mid-run → all outputs 0 on the next edge.
